// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B4 round-robin arbiter onto one slave; grant registered one edge after request.
// Zero added wait states once granted; a waiting master holds cyc and sees ack=0 until it is granted.
module wb_arbiter_2m #(
  parameter int ADR_W    = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [3:0]       m0_sel,
  input  logic [31:0]      m0_dat_ms,
  input  logic [2:0]       m0_cti,
  input  logic [1:0]       m0_bte,
  output logic             m0_ack,
  output logic [31:0]      m0_dat_sm,

  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [3:0]       m1_sel,
  input  logic [31:0]      m1_dat_ms,
  input  logic [2:0]       m1_cti,
  input  logic [1:0]       m1_bte,
  output logic             m1_ack,
  output logic [31:0]      m1_dat_sm,

  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [3:0]       s_sel,
  output logic [31:0]      s_dat_ms,
  output logic [2:0]       s_cti,
  output logic [1:0]       s_bte,
  input  logic             s_ack,
  input  logic [31:0]      s_dat_sm,

  output logic [1:0]       gnt
);

  // One-hot state encoding doubles as the grant vector.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GNT0 = 2'b01;
  localparam logic [1:0] ST_GNT1 = 2'b10;

  localparam int HC_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  logic [1:0]      state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]      gnt_q, gnt_d;

  logic end_xfer;
  logic hold_expire;

  // Slave port mux: the granted master drives the slave, everyone else is masked.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state_q)
      ST_GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_dat_ms = m0_dat_ms;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
      end
      ST_GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_ms = m1_dat_ms;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // Only classic cycles and end-of-burst beats are safe points to hand the bus over.
  assign end_xfer    = s_ack && s_cyc && s_stb && ((s_cti == 3'b000) || (s_cti == 3'b111));
  assign hold_expire = HOLD_EN && (hold_cnt_q == HOLD_LAST) && end_xfer;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_d = last_gnt_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc) begin
          state_d = ST_GNT0;
        end else if (m1_cyc) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc) begin
          state_d = m1_cyc ? ST_GNT1 : ST_IDLE;
        end else if (hold_expire && m1_cyc) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc) begin
          state_d = m0_cyc ? ST_GNT0 : ST_IDLE;
        end else if (hold_expire && m0_cyc) begin
          state_d = ST_GNT0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (HOLD_EN && end_xfer && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    // A fresh grant restarts the fairness budget and records the winner.
    if ((state_d != state_q) && (state_d != ST_IDLE)) begin
      hold_cnt_d = '0;
      last_gnt_d = (state_d == ST_GNT1);
    end

    gnt_d = state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      hold_cnt_q <= '0;
      gnt_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m (MAX_HOLD=4): forced-ack vector table, then bursts against a zero-wait RAM.
module tb_wb_arbiter_2m;

  localparam int ADR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             m0_cyc, m0_stb, m0_we, m0_ack;
  logic [ADR_W-1:0] m0_adr;
  logic [3:0]       m0_sel;
  logic [31:0]      m0_dat_ms, m0_dat_sm;
  logic [2:0]       m0_cti;
  logic [1:0]       m0_bte;
  logic             m1_cyc, m1_stb, m1_we, m1_ack;
  logic [ADR_W-1:0] m1_adr;
  logic [3:0]       m1_sel;
  logic [31:0]      m1_dat_ms, m1_dat_sm;
  logic [2:0]       m1_cti;
  logic [1:0]       m1_bte;
  logic             s_cyc, s_stb, s_we, s_ack;
  logic [ADR_W-1:0] s_adr;
  logic [3:0]       s_sel;
  logic [31:0]      s_dat_ms, s_dat_sm;
  logic [2:0]       s_cti;
  logic [1:0]       s_bte;
  logic [1:0]       gnt;

  wb_arbiter_2m #(.ADR_W(ADR_W), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
    .m0_dat_ms(m0_dat_ms), .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
    .m1_dat_ms(m1_dat_ms), .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_ms(s_dat_ms), .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
    .gnt(gnt)
  );

  // Zero-wait RAM slave; the table phase overrides its ack directly.
  logic        ack_force_mode = 1'b1;
  logic        ack_frc = 1'b0;
  logic [31:0] mem [0:63];
  assign s_ack    = ack_force_mode ? ack_frc : (s_cyc & s_stb);
  assign s_dat_sm = mem[s_adr[7:2]];
  always @(posedge clk)
    if (!ack_force_mode && s_cyc && s_stb && s_we && s_ack) mem[s_adr[7:2]] <= s_dat_ms;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic in_burst = 1'b0;
  int   m0_ack_burst = 0;
  always @(negedge clk) if (in_burst && m0_ack) m0_ack_burst++;

  typedef struct {
    logic        rst_n, c0, c1, ack;
    logic [1:0]  gnt;
    logic        s_cyc, a0, a1;
    logic [31:0] adr;
  } vec_t;
  vec_t tbl [20];

  function automatic vec_t mk(input logic r, input logic c0, input logic c1, input logic a,
                              input logic [1:0] g, input logic sc, input logic a0,
                              input logic a1, input logic [31:0] ad);
    vec_t v;
    v.rst_n = r; v.c0 = c0; v.c1 = c1; v.ack = a;
    v.gnt = g; v.s_cyc = sc; v.a0 = a0; v.a1 = a1; v.adr = ad;
    return v;
  endfunction

  function automatic logic [31:0] pat(input int i);
    return 32'hB000_0000 + 32'(i) * 32'h0011_1111;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic masters_idle();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = 4'hF; m0_dat_ms = '0; m0_cti = '0; m0_bte = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = 4'hF; m1_dat_ms = '0; m1_cti = '0; m1_bte = '0;
  endtask

  task automatic do_reset();
    masters_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One beat from master m: drive, wait (bounded) for its ack, pop/compare read data, step past the edge.
  task automatic m_beat(input int m, input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [2:0] cti, input logic [31:0] exp_rd);
    logic got;
    if (m == 0) begin
      m0_cyc = 1; m0_stb = 1; m0_we = we; m0_adr = adr; m0_dat_ms = dat; m0_cti = cti;
    end else begin
      m1_cyc = 1; m1_stb = 1; m1_we = we; m1_adr = adr; m1_dat_ms = dat; m1_cti = cti;
    end
    if (!we) exp_q.push_back(exp_rd);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ack : m1_ack;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout m%0d adr %h: got no ack, required ack within 40 cycles", m, adr);
      if (!we) void'(exp_q.pop_front());
    end else if (!we) begin
      chk($sformatf("rd_m%0d_%h", m, adr), 64'((m == 0) ? m0_dat_sm : m1_dat_sm), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic flipped;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    masters_idle();

    //          rst c0 c1 ack  gnt   scyc a0 a1 s_adr
    tbl[0]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    tbl[3]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    tbl[4]  = mk(1, 0, 0, 1, 2'b00, 0, 0, 0, 32'h0);
    tbl[5]  = mk(1, 1, 0, 0, 2'b01, 1, 0, 0, 32'h10);
    tbl[6]  = mk(1, 1, 0, 1, 2'b01, 1, 1, 0, 32'h10);
    tbl[7]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    tbl[8]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    tbl[9]  = mk(1, 1, 1, 0, 2'b01, 1, 0, 0, 32'h10);
    tbl[10] = mk(1, 1, 1, 1, 2'b01, 1, 1, 0, 32'h10);
    tbl[11] = mk(1, 0, 1, 0, 2'b10, 1, 0, 0, 32'h20);
    tbl[12] = mk(1, 1, 1, 1, 2'b10, 1, 0, 1, 32'h20);
    tbl[13] = mk(1, 1, 0, 0, 2'b01, 1, 0, 0, 32'h10);
    tbl[14] = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    tbl[15] = mk(1, 1, 1, 0, 2'b10, 1, 0, 0, 32'h20);
    tbl[16] = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
    tbl[17] = mk(1, 1, 1, 0, 2'b01, 1, 0, 0, 32'h10);
    tbl[18] = mk(0, 1, 1, 1, 2'b00, 0, 0, 0, 32'h0);
    tbl[19] = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0);

    ack_force_mode = 1'b1;
    m0_adr = 32'h10;
    m1_adr = 32'h20;
    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst_n;
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1;
      ack_frc = tbl[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {27'd0, gnt, s_cyc, m0_ack, m1_ack, s_adr},
          {27'd0, tbl[i].gnt, tbl[i].s_cyc, tbl[i].a0, tbl[i].a1, tbl[i].adr});
    end
    ack_force_mode = 1'b0;
    ack_frc = 1'b0;

    // Fair-hold: m0 streams classic writes while m1 waits; m1 wins after m0's 4th ack.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0C; m0_dat_ms = 32'h1234_5678; m0_cti = 3'b000;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h20; m1_cti = 3'b000;
    cnt = 0;
    flipped = 1'b0;
    for (int k = 0; k < 30 && !flipped; k++) begin
      @(negedge clk);
      if (gnt == 2'b10) flipped = 1'b1;
      else if (m0_ack) cnt++;
    end
    chk("hold_m0_acks_before_switch", 64'(cnt), 64'd4);
    chk("hold_switch_acks", {62'd0, m0_ack, m1_ack}, {62'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_m0_starved", 64'(m0_ack), 64'd0);
    @(posedge clk); #1;
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    chk("hold_release_cycle", {62'd0, m0_ack, s_cyc}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_m0_regrant", {61'd0, gnt, m0_ack}, {61'd0, 2'b01, 1'b1});
    @(posedge clk); #1;
    masters_idle();

    // m1: three classic writes (hold reaches 3), then an 8-beat burst with m0 arriving mid-burst.
    do_reset();
    for (int i = 0; i < 3; i++) m_beat(1, 32'h80 + 32'(4 * i), pat(100 + i), 1'b1, 3'b000, '0);
    in_burst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h40; m0_cti = 3'b000;
      end
      m_beat(1, 32'h40 + 32'(4 * i), pat(i), 1'b1, (i == 7) ? 3'b111 : 3'b010, '0);
    end
    in_burst = 1'b0;
    m1_we = 0; m1_cti = 3'b000; m1_adr = 32'h40;
    chk("burst_end_preempt_gnt", 64'(gnt), 64'(2'b01));
    chk("burst_no_m0_ack_inside", 64'(m0_ack_burst), 64'd0);
    m_beat(0, 32'h40, '0, 1'b0, 3'b000, pat(0));
    m0_cyc = 0; m0_stb = 0;
    for (int i = 0; i < 8; i++) m_beat(1, 32'h40 + 32'(4 * i), '0, 1'b0, 3'b000, pat(i));
    m_beat(1, 32'h88, '0, 1'b0, 3'b000, pat(102));
    masters_idle();

    // Reset in the middle of an m0 burst, then clean re-grant.
    do_reset();
    m_beat(0, 32'h60, pat(20), 1'b1, 3'b010, '0);
    m_beat(0, 32'h64, pat(21), 1'b1, 3'b010, '0);
    m0_adr = 32'h68; m0_dat_ms = pat(22); m0_cti = 3'b010;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_s_cyc_stb", {62'd0, s_cyc, s_stb}, 64'd0);
    chk("rst_mid_gnt", 64'(gnt), 64'd0);
    chk("rst_mid_m0_ack", 64'(m0_ack), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_regrant", {61'd0, gnt, m0_ack}, {61'd0, 2'b01, 1'b1});
    m_beat(0, 32'h68, pat(22), 1'b1, 3'b111, '0);
    m0_cyc = 0; m0_stb = 0;
    m_beat(1, 32'h60, '0, 1'b0, 3'b000, pat(20));
    m_beat(1, 32'h68, '0, 1'b0, 3'b000, pat(22));
    masters_idle();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
